iterative_signed_or_unsigned_mul: RTL and testbench
===================================================

# iterative_signed_or_unsigned_mul

Multi-cycle, parametrised multiplier producing the signed or unsigned 2N-bit product of two N-bit operands; the mode is chosen per transaction. It computes one multiplier bit per clock using a shift-add datapath over operand magnitudes. Sign correction is applied at the end. It replaces the single-cycle combinational multiplier where area matters more than throughput, and connects to neighbouring pipeline stages through valid/ready handshakes on both sides.

## Interface
- `N`, default 8: operand width, N ≥ 2; result width is 2N.
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `arg_vld`  input  1  operands valid.
- `arg_rdy`  output  1  block can accept operands.
- `a`, `b`  input  N each  operands; two's complement when `signed_mul`=1, unsigned otherwise.
- `signed_mul`  input  1  mode, sampled with the operands.
- `res_vld`  output  1  result valid.
- `res_rdy`  input  1  downstream accepts the result.
- `res`  output  2N  product modulo 2^2N.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `arg_rdy`=1. On `arg_vld`&&`arg_rdy`, latch the operands and the mode, then go to BUSY with step counter 0.
  - BUSY: on each cycle, if the current LSB of the multiplier magnitude is 1, add the shifted multiplicand to the accumulator. Then shift and increment the counter. After the step with counter = N−1, go to DONE.
  - DONE: `res_vld`=1 and `res` is stable. On `res_vld`&&`res_rdy`, go to IDLE.
- Operands are ignored outside IDLE. `arg_rdy`=0 in BUSY and DONE.
- Signed mode:
  - The magnitude of each operand is its conditionally negated value. The magnitude of −2^(N−1) is 2^(N−1), which fits in N unsigned bits.
  - The final product is negated when exactly one operand is negative.
  - Negation is two's complement over 2N bits.
- Unsigned mode: operands are used directly with no final negation.
- The accumulator is 2N bits and cannot overflow: the maximum magnitude is (2^N−1)^2.
- Reset, at any state including mid-BUSY or DONE: the next state is IDLE and the accumulator and counter are cleared. Any in-flight transaction is dropped with no result.
- Output values while `rst`=1 and on the cycle after: `arg_rdy`=0 during reset, `res_vld`=0, `res`=0.

## Timing
- Acceptance edge T (IDLE, `arg_vld`&&`arg_rdy`) → BUSY during cycles T+1 … T+N → `res_vld`=1 from cycle T+N+1.
- Latency is N+1 cycles from acceptance to the first `res_vld`.
- `res_vld` and `res` are held unchanged until the `res_rdy` handshake. Backpressure has no upper bound.
- After the result handshake edge, `arg_rdy`=1 on the next cycle. There is no same-cycle accept, so peak throughput is one result per N+2 cycles.
- `res` holds its last value in IDLE and BUSY. It is only meaningful when `res_vld`=1.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- `ITERATIVE_MUL_EARLY_TERM_EN` defined: in BUSY, when the remaining unshifted multiplier magnitude is zero at the start of a cycle, go directly to DONE that cycle. The sign fix-up still applies.
  - Latency becomes 1 + max(1, index of the highest set multiplier bit + 1) cycles.
  - A zero multiplier reaches DONE after 1 BUSY cycle.
- Undefined: every transaction takes exactly N BUSY cycles, giving the fixed latency N+1.
- Results are bit-identical in both builds.

## Structure
- Shared package `mul_pkg`:
  - state enum typedef `mul_state_t` (IDLE, BUSY, DONE);
  - a localparam helper for the counter width, $clog2(N).
- One sub-module, `cond_negate #(W)`: combinational W-bit two's-complement negation when `neg`=1. It is instantiated for both operand magnitudes (W=N) and the final product (W=2N).
- The top level holds the FSM, counter, accumulator and shift registers.

## Test plan
- N=8, unsigned, a=255, b=255 → `res`=0xFE01, with `res_vld` exactly 9 cycles after acceptance (build without the macro).
- N=8, signed, a=0x80 (−128), b=0x80 → `res`=0x4000. Also signed a=0x80, b=0x7F → `res`=0xC080 (−16256).
- N=8, signed, a=0xFF, b=0xFF → `res`=0x0001. The same operands in unsigned mode → `res`=0xFE01.
- Backpressure: `res_rdy`=0 for 20 cycles after `res_vld` → `res_vld` and `res` stay stable and `arg_rdy` stays 0. When `res_rdy`=1, the handshake completes and `arg_rdy`=1 on the next cycle.
- Reset mid-operation: assert `rst` for 1 cycle at BUSY step 3 → the next cycle is IDLE with `res_vld`=0 and `res`=0, and no result appears. A fresh transaction 3×5 → `res`=15.
- With `ITERATIVE_MUL_EARLY_TERM_EN`: N=16, a=1234, b=1 → `res_vld` 2 cycles after acceptance, `res`=1234. Then b=0 → `res`=0 after 2 cycles. Then N=8 random regression against a reference model of a*b in both modes.

Source files
------------

// File: rtl/iterative_signed_or_unsigned_mul_pkg.sv
// Shared definitions for the iterative signed/unsigned multiplier.
//
// Contents:
//   mul_state_t  - controller states (IDLE, BUSY, DONE)
//   cnt_width()  - width of the step counter, which holds 0 .. N-1
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_t;

  // A counter for N steps needs $clog2(N) bits. The clamp keeps the width
  // at one bit or more for any N.
  function automatic int cnt_width(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iterative_signed_or_unsigned_mul_cond_negate.sv
// Conditional two's-complement negation.
//
// Parameters:
//   W      - data width
// Ports:
//   val_i  - input value
//   neg_i  - 1: output is -val_i modulo 2^W, 0: output is val_i
//   val_o  - result (combinational)
module cond_negate #(
  parameter int W = 8
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/iterative_signed_or_unsigned_mul.sv
// Iterative shift-add multiplier with a per-transaction signed/unsigned mode.
// Each clock processes one multiplier bit. The operands are converted to
// magnitudes when they are accepted, and the sign is applied to the product
// at the end.
//
// Parameters:
//   N           - operand width (N >= 2); the product is 2N bits
// Ports:
//   clk         - clock; all logic is on the rising edge
//   rst         - synchronous active-high reset
//   arg_vld     - operands valid
//   arg_rdy     - block can accept operands (IDLE only)
//   a, b        - operands; two's complement when signed_mul = 1
//   signed_mul  - mode, sampled together with the operands
//   res_vld     - result valid; held until res_rdy
//   res_rdy     - downstream accepts the result
//   res         - product modulo 2^(2N)
//
// Build option:
//   ITERATIVE_MUL_EARLY_TERM_EN - finish BUSY as soon as no set multiplier
//                                 bits remain. The results do not change.
module iterative_signed_or_unsigned_mul
  import mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arg_vld,
  output logic           arg_rdy,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mul,
  output logic           res_vld,
  input  logic           res_rdy,
  output logic [2*N-1:0] res
);

  localparam int CW = cnt_width(N);

  mul_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [2*N-1:0]   acc_q;
  logic [2*N-1:0]   acc_d;
  logic [2*N-1:0]   mcand_q;
  logic [N-1:0]     mplier_q;
  logic             neg_q;
  logic             arg_rdy_q;
  logic             res_vld_q;
  logic [2*N-1:0]   res_q;

  logic [N-1:0]     mag_a;
  logic [N-1:0]     mag_b;
  logic [2*N-1:0]   prod_final;
  logic             last_step;

  // Operand magnitudes. The magnitude of -2^(N-1) is 2^(N-1), which still
  // fits in N unsigned bits.
  cond_negate #(.W(N)) u_neg_a (
    .val_i (a),
    .neg_i (signed_mul & a[N-1]),
    .val_o (mag_a)
  );

  cond_negate #(.W(N)) u_neg_b (
    .val_i (b),
    .neg_i (signed_mul & b[N-1]),
    .val_o (mag_b)
  );

  // Accumulator value after this cycle's conditional add. On the last step
  // this value is the unsigned product of the magnitudes.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  cond_negate #(.W(2*N)) u_neg_p (
    .val_i (acc_d),
    .neg_i (neg_q),
    .val_o (prod_final)
  );

`ifdef ITERATIVE_MUL_EARLY_TERM_EN
  // Stop when no set bits remain above the current LSB. A zero multiplier
  // therefore still takes one BUSY cycle.
  assign last_step = (cnt_q == CW'(N - 1)) || (mplier_q[N-1:1] == '0);
`else
  assign last_step = (cnt_q == CW'(N - 1));
`endif

  // Controller and datapath. The handshake outputs are registered. arg_rdy
  // rises one cycle after the controller enters IDLE, so it is low during
  // reset and on the cycle that follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      arg_rdy_q <= 1'b0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arg_vld && arg_rdy_q) begin
            mcand_q   <= {{N{1'b0}}, mag_a};
            mplier_q  <= mag_b;
            neg_q     <= signed_mul & (a[N-1] ^ b[N-1]);
            acc_q     <= '0;
            cnt_q     <= '0;
            arg_rdy_q <= 1'b0;
            state_q   <= BUSY;
          end else begin
            arg_rdy_q <= 1'b1;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_step) begin
            res_q     <= prod_final;
            res_vld_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (res_rdy) begin
            res_vld_q <= 1'b0;
            arg_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign arg_rdy = arg_rdy_q;
  assign res_vld = res_vld_q;
  assign res     = res_q;

endmodule

// File: tb/tb_iterative_signed_or_unsigned_mul.sv
// Self-checking bench for iterative_signed_or_unsigned_mul with N = 8.
// It runs directed corner cases, backpressure, a mid-operation reset and a
// random regression. Results are compared with a plain-arithmetic reference
// product and a latency model that follows the build option.
module tb_iterative_signed_or_unsigned_mul;

  localparam int N = 8;
`ifdef ITERATIVE_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           arg_vld;
  logic           arg_rdy;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           signed_mul;
  logic           res_vld;
  logic           res_rdy;
  logic [2*N-1:0] res;

  int vectors = 0;
  int miscompares = 0;

  iterative_signed_or_unsigned_mul #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .arg_vld    (arg_vld),
    .arg_rdy    (arg_rdy),
    .a          (a),
    .b          (b),
    .signed_mul (signed_mul),
    .res_vld    (res_vld),
    .res_rdy    (res_rdy),
    .res        (res)
  );

  always #5 clk = ~clk;

  // Reference product: the operands are interpreted as integers and
  // multiplied, then the result is reduced modulo 2^16.
  function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y,
                                             input logic s);
    int sx;
    int sy;
    int p;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    p  = sx * sy;
    return p[15:0];
  endfunction

  // Cycles from acceptance to the first res_vld.
  function automatic int refLatency(input logic [7:0] y, input logic s);
    int m;
    int hi;
    m  = s ? int'($signed(y)) : int'(y);
    if (m < 0) m = -m;
    hi = -1;
    for (int i = 0; i < 9; i++) if (m >= (1 << i)) hi = i;
    if (EARLY) return 1 + (((hi + 1) > 1) ? (hi + 1) : 1);
    return N + 1;
  endfunction

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one operand pair. Return the latency and the first valid result.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic s,
                               output int lat, output logic [15:0] r);
    int guard;
    guard = 0;
    while (!arg_rdy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!arg_rdy) checkOutput("arg_rdy_timeout", {31'd0, arg_rdy}, 32'd1);
    a = x;
    b = y;
    signed_mul = s;
    arg_vld = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    signed_mul = 1'($urandom);
    lat = 1;
    while (!res_vld && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!res_vld) checkOutput("res_vld_timeout", {31'd0, res_vld}, 32'd1);
    r = res;
  endtask

  // Complete the result handshake. Check that arg_rdy is high on the next
  // cycle and that res keeps its value in IDLE.
  task automatic finishResult(input string tag, input logic [15:0] expRes);
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
    checkOutput({tag, "_argrdy_after"}, {31'd0, arg_rdy}, 32'd1);
    checkOutput({tag, "_res_hold"}, {16'd0, res}, {16'd0, expRes});
  endtask

  // Run one full transaction and check the product and latency.
  task automatic runTxn(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s);
    int lat;
    logic [15:0] r;
    logic [15:0] e;
    e = refProduct(x, y, s);
    applyStimulus(x, y, s, lat, r);
    checkOutput({tag, "_res"}, {16'd0, r}, {16'd0, e});
    checkOutput({tag, "_lat"}, lat, refLatency(y, s));
    finishResult(tag, e);
  endtask

  initial begin
    int lat;
    logic [15:0] r;
    logic [15:0] held;
    logic sawValid;
    logic [7:0] rx;
    logic [7:0] ry;
    logic rs;

    rst = 1'b1;
    arg_vld = 1'b0;
    a = '0;
    b = '0;
    signed_mul = 1'b0;
    res_rdy = 1'b0;

    // Check the outputs while reset is held.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_arg_rdy", {31'd0, arg_rdy}, 32'd0);
    checkOutput("reset_res_vld", {31'd0, res_vld}, 32'd0);
    checkOutput("reset_res", {16'd0, res}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_res_vld", {31'd0, res_vld}, 32'd0);
    checkOutput("post_reset_arg_rdy", {31'd0, arg_rdy}, 32'd1);

    // Directed corner cases.
    runTxn("u_ff_ff", 8'hFF, 8'hFF, 1'b0);
    checkOutput("u_ff_ff_value", {16'd0, res}, 32'h0000_FE01);
    runTxn("s_80_80", 8'h80, 8'h80, 1'b1);
    checkOutput("s_80_80_value", {16'd0, res}, 32'h0000_4000);
    runTxn("s_80_7f", 8'h80, 8'h7F, 1'b1);
    checkOutput("s_80_7f_value", {16'd0, res}, 32'h0000_C080);
    runTxn("s_ff_ff", 8'hFF, 8'hFF, 1'b1);
    checkOutput("s_ff_ff_value", {16'd0, res}, 32'h0000_0001);
    runTxn("u_7b_01", 8'd123, 8'd1, 1'b0);
    runTxn("u_7b_00", 8'd123, 8'd0, 1'b0);
    runTxn("s_00_80", 8'h00, 8'h80, 1'b1);
    runTxn("s_05_fd", 8'h05, 8'hFD, 1'b1);

    // Backpressure: the result must stay frozen while res_rdy is low.
    applyStimulus(8'd200, 8'd3, 1'b0, lat, r);
    checkOutput("bp_res", {16'd0, r}, {16'd0, refProduct(8'd200, 8'd3, 1'b0)});
    held = r;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp_res_vld", {31'd0, res_vld}, 32'd1);
      checkOutput("bp_res_stable", {16'd0, res}, {16'd0, held});
      checkOutput("bp_arg_rdy", {31'd0, arg_rdy}, 32'd0);
    end
    finishResult("bp", held);

    // Reset during BUSY step 3. Afterwards no result may appear.
    a = 8'd7;
    b = 8'hFF;
    signed_mul = 1'b0;
    arg_vld = 1'b1;
    @(negedge clk);
    arg_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_arg_rdy", {31'd0, arg_rdy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_res_vld", {31'd0, res_vld}, 32'd0);
    checkOutput("midrst_res", {16'd0, res}, 32'd0);
    checkOutput("midrst_arg_rdy", {31'd0, arg_rdy}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (res_vld) sawValid = 1'b1;
    end
    checkOutput("midrst_no_result", {31'd0, sawValid}, 32'd0);
    runTxn("fresh_3x5", 8'd3, 8'd5, 1'b0);
    checkOutput("fresh_3x5_value", {16'd0, res}, 32'd15);

    // Random regression in both modes.
    for (int i = 0; i < 40; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom_range(0, 255));
      if (i % 8 == 0) ry = 8'($urandom_range(0, 3));
      rs = 1'($urandom);
      runTxn($sformatf("rand%0d", i), rx, ry, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
